pingpang_tx_buf: RTL and testbench

PINGPANG_TX_BUF -- requirements
Module: pingpang_tx_buf

---
 rtl/pingpang_pkg.sv | 19 +
 rtl/pingpang_bank_ram.sv | 30 +++
 rtl/pingpang_tx_buf.sv | 192 +++++++++++++++++++
 tb/tb_pingpang_tx_buf.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pingpang_pkg.sv
// Shared types and constants for the ping-pong transmit buffer.
package pingpang_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_status_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Address issue to O_rDataEn: one cycle of RAM read plus one output register.
  localparam int unsigned RD_LATENCY = 2;

endpackage

// File: rtl/pingpang_bank_ram.sv
// Simple dual-port bank RAM: one write port, one read port with 1-cycle registered read.
module pingpang_bank_ram #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pingpang_tx_buf.sv
// Ping-pong block buffer: producer fills one bank while the other streams out.
// Optional saturating underflow counter enabled by PINGPANG_TX_UNDERFLOW_CNT_EN.
module pingpang_tx_buf
  import pingpang_pkg::*;
#(
  parameter int unsigned C_WDATA_WIDTH = 32,
  parameter int unsigned C_WADDR_WIDTH = 10,
  parameter int unsigned C_BLOCK_LEN   = 20
) (
  input  logic                     I_clk,
  input  logic                     I_rst_n,
  input  logic                     I_wDataEn,
  input  logic [C_WDATA_WIDTH-1:0] I_wData,
  output logic                     O_wReady,
  input  logic                     I_rReady,
  output logic                     O_rDataEn,
  output logic [C_WDATA_WIDTH-1:0] O_rData,
  output logic                     O_rLast
`ifdef PINGPANG_TX_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]              O_underflowCnt
`endif
);

  localparam logic [C_WADDR_WIDTH-1:0] LAST_ADDR = C_WADDR_WIDTH'(C_BLOCK_LEN - 1);

  bank_status_e [1:0]       status_q, status_d;
  rd_state_e                rstate_q, rstate_d;
  logic                     wsel_q, wsel_d, rsel_q, rsel_d;
  logic [C_WADDR_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic                     wready_q, wready_d;
  logic                     issue_q, issue_d, ibank_q, ibank_d, ilast_q, ilast_d;
  logic                     vld2_q, vld2_d, bank2_q, bank2_d, last2_q, last2_d;
  logic                     rdataen_q, rdataen_d, rlast_q, rlast_d;
  logic [C_WDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [C_WDATA_WIDTH-1:0] dout0, dout1;
  logic                     wr_acc_c, issue_c;
  logic [C_WADDR_WIDTH-1:0] iaddr_c;

  // Write side and read FSM touch disjoint banks, so updates compose in one pass.
  always_comb begin
    status_d  = status_q;
    rstate_d  = rstate_q;
    wsel_d    = wsel_q;
    rsel_d    = rsel_q;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    issue_d   = 1'b0;
    ibank_d   = ibank_q;
    ilast_d   = 1'b0;
    issue_c   = 1'b0;
    iaddr_c   = '0;
    wr_acc_c  = I_wDataEn & wready_q;

    if (wr_acc_c) begin
      if (waddr_q == LAST_ADDR) begin
        status_d[wsel_q] = BANK_FULL;
        wsel_d           = ~wsel_q;
        waddr_d          = '0;
      end else begin
        status_d[wsel_q] = BANK_FILLING;
        waddr_d          = waddr_q + C_WADDR_WIDTH'(1);
      end
    end

    unique case (rstate_q)
      RD_IDLE: begin
        if (status_q[rsel_q] == BANK_FULL && I_rReady) issue_c = 1'b1;
      end
      RD_READ: begin
        if (I_rReady) begin
          issue_c = 1'b1;
          iaddr_c = (raddr_q == LAST_ADDR) ? '0 : raddr_q + C_WADDR_WIDTH'(1);
        end
      end
      default: ;
    endcase

    if (issue_c) begin
      raddr_d          = iaddr_c;
      issue_d          = 1'b1;
      ibank_d          = rsel_q;
      status_d[rsel_q] = BANK_DRAINING;
      rstate_d         = RD_READ;
      if (iaddr_c == LAST_ADDR) begin
        status_d[rsel_q] = BANK_EMPTY;
        rsel_d           = ~rsel_q;
        ilast_d          = 1'b1;
        if (status_q[!rsel_q] != BANK_FULL) rstate_d = RD_IDLE;
      end
    end

    wready_d  = (status_d[wsel_d] == BANK_EMPTY) || (status_d[wsel_d] == BANK_FILLING);

    vld2_d    = issue_q;
    bank2_d   = ibank_q;
    last2_d   = ilast_q;
    rdataen_d = vld2_q;
    rlast_d   = vld2_q & last2_q;
    rdata_d   = rdata_q;
    if (vld2_q) rdata_d = bank2_q ? dout1 : dout0;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      status_q[0] <= BANK_EMPTY;
      status_q[1] <= BANK_EMPTY;
      rstate_q    <= RD_IDLE;
      wsel_q      <= 1'b0;
      rsel_q      <= 1'b0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      wready_q    <= 1'b0;
      issue_q     <= 1'b0;
      ibank_q     <= 1'b0;
      ilast_q     <= 1'b0;
      vld2_q      <= 1'b0;
      bank2_q     <= 1'b0;
      last2_q     <= 1'b0;
      rdataen_q   <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      status_q    <= status_d;
      rstate_q    <= rstate_d;
      wsel_q      <= wsel_d;
      rsel_q      <= rsel_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      wready_q    <= wready_d;
      issue_q     <= issue_d;
      ibank_q     <= ibank_d;
      ilast_q     <= ilast_d;
      vld2_q      <= vld2_d;
      bank2_q     <= bank2_d;
      last2_q     <= last2_d;
      rdataen_q   <= rdataen_d;
      rlast_q     <= rlast_d;
      rdata_q     <= rdata_d;
    end
  end

  pingpang_bank_ram #(.DW(C_WDATA_WIDTH), .AW(C_WADDR_WIDTH)) u_bank0 (
    .clk   (I_clk),
    .we    (wr_acc_c & ~wsel_q),
    .waddr (waddr_q),
    .wdata (I_wData),
    .re    (issue_q & ~ibank_q),
    .raddr (raddr_q),
    .rdata (dout0)
  );

  pingpang_bank_ram #(.DW(C_WDATA_WIDTH), .AW(C_WADDR_WIDTH)) u_bank1 (
    .clk   (I_clk),
    .we    (wr_acc_c & wsel_q),
    .waddr (waddr_q),
    .wdata (I_wData),
    .re    (issue_q & ibank_q),
    .raddr (raddr_q),
    .rdata (dout1)
  );

  assign O_wReady  = wready_q;
  assign O_rDataEn = rdataen_q;
  assign O_rData   = rdata_q;
  assign O_rLast   = rlast_q;

`ifdef PINGPANG_TX_UNDERFLOW_CNT_EN
  logic        done_q, done_d;
  logic [15:0] ucnt_q, ucnt_d;

  // Counts ready-but-starved cycles once the first block has gone out.
  always_comb begin
    done_d = done_q | ilast_d;
    ucnt_d = ucnt_q;
    if (done_q && I_rReady && !issue_c && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      done_q <= 1'b0;
      ucnt_q <= '0;
    end else begin
      done_q <= done_d;
      ucnt_q <= ucnt_d;
    end
  end

  assign O_underflowCnt = ucnt_q;
`endif

endmodule

// File: tb/tb_pingpang_tx_buf.sv
// Self-checking bench for pingpang_tx_buf (block length 20, 32-bit words).
module tb_pingpang_tx_buf;
  import pingpang_pkg::*;

  localparam int unsigned BL = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wen;
  logic [31:0] wdata;
  logic        wready;
  logic        rready;
  logic        rdataen;
  logic [31:0] rdata;
  logic        rlast;
`ifdef PINGPANG_TX_UNDERFLOW_CNT_EN
  logic [15:0] ucnt;
`endif

  always #5 clk = ~clk;

  pingpang_tx_buf #(.C_WDATA_WIDTH(32), .C_WADDR_WIDTH(10), .C_BLOCK_LEN(BL)) dut (
    .I_clk     (clk),
    .I_rst_n   (rst_n),
    .I_wDataEn (wen),
    .I_wData   (wdata),
    .O_wReady  (wready),
    .I_rReady  (rready),
    .O_rDataEn (rdataen),
    .O_rData   (rdata),
    .O_rLast   (rlast)
`ifdef PINGPANG_TX_UNDERFLOW_CNT_EN
    ,
    .O_underflowCnt (ucnt)
`endif
  );

  typedef struct {
    int unsigned n_strobes;
    logic        rready_w;
    int unsigned exp_acc;
    int unsigned exp_out;
    logic        chk_lat;
    logic        chk_contig;
  } case_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          out_cnt = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  int          acc19_cyc = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] tag(input int id, input int i);
    return {8'(id), 8'h5A, 16'(i)};
  endfunction

  // One clock; outputs are sampled 1ns after the edge and checked against the queue.
  task automatic step();
    logic [31:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n && rdataen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", rdata, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", rdata, e);
        chk("rlast", 32'(rlast), 32'((out_cnt % BL) == BL - 1));
      end
      if (out_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      out_cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    wen    = 1'b0;
    wdata  = '0;
    rready = 1'b0;
    exp_q.delete();
    out_cnt = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic write_words(input int id, input int n, input int n_acc);
    for (int i = 0; i < n; i++) begin
      wen   = 1'b1;
      wdata = tag(id, i);
      chk($sformatf("wready_c%0d_w%0d", id, i), 32'(wready), 32'(i < n_acc));
      if (i < n_acc) exp_q.push_back(tag(id, i));
      step();
      if (i == BL - 1) acc19_cyc = cyc;
    end
    wen = 1'b0;
  endtask

  task automatic wait_out(input int target);
    int n = 0;
    while (out_cnt < target && n < 300) begin
      step();
      n++;
    end
    if (out_cnt < target) chk("wait_timeout", 32'(out_cnt), 32'(target));
  endtask

  task automatic run_case(input case_t tc, input int id);
    do_reset();
    rready = tc.rready_w;
    write_words(id, int'(tc.n_strobes), int'(tc.exp_acc));
    rready = 1'b1;
    wait_out(int'(tc.exp_out));
    repeat (10) step();
    chk($sformatf("out_cnt_c%0d", id), 32'(out_cnt), 32'(tc.exp_out));
    if (tc.chk_lat) chk($sformatf("latency_c%0d", id), 32'(first_cyc - acc19_cyc), 32'(RD_LATENCY + 1));
    if (tc.chk_contig) chk($sformatf("contig_c%0d", id), 32'(last_cyc - first_cyc), 32'(tc.exp_out - 1));
  endtask

  case_t cases[5];

  initial begin
    cases[0] = '{n_strobes: 20, rready_w: 1'b1, exp_acc: 20, exp_out: 20, chk_lat: 1'b1, chk_contig: 1'b1};
    cases[1] = '{n_strobes: 40, rready_w: 1'b1, exp_acc: 40, exp_out: 40, chk_lat: 1'b1, chk_contig: 1'b1};
    cases[2] = '{n_strobes: 60, rready_w: 1'b0, exp_acc: 40, exp_out: 40, chk_lat: 1'b0, chk_contig: 1'b1};
    cases[3] = '{n_strobes: 7,  rready_w: 1'b1, exp_acc: 7,  exp_out: 0,  chk_lat: 1'b0, chk_contig: 1'b0};
    cases[4] = '{n_strobes: 25, rready_w: 1'b0, exp_acc: 25, exp_out: 20, chk_lat: 1'b0, chk_contig: 1'b0};

    // Reset values, and O_wReady rising on the first edge after release.
    rst_n = 1'b0; wen = 1'b0; wdata = '0; rready = 1'b0;
    #1;
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rdataen", 32'(rdataen), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("rel_wready_before_edge", 32'(wready), 32'd0);
    step();
    chk("rel_wready_after_edge", 32'(wready), 32'd1);

    for (int c = 0; c < 5; c++) run_case(cases[c], c);

    // Consumer stalls for 5 cycles after word 7 appears.
    do_reset();
    write_words(10, 40, 40);
    rready = 1'b1;
    wait_out(8);
    rready = 1'b0;
    repeat (5) step();
    chk("stall_inflight", 32'(out_cnt), 32'd10);
    rready = 1'b1;
    wait_out(40);
    repeat (5) step();
    chk("stall_total", 32'(out_cnt), 32'd40);
    chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset asserted while draining at word 10.
    do_reset();
    write_words(11, 20, 20);
    rready = 1'b1;
    wait_out(11);
    rst_n = 1'b0;
    #1;
    chk("midrst_wready", 32'(wready), 32'd0);
    chk("midrst_rdataen", 32'(rdataen), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_rlast", 32'(rlast), 32'd0);
    exp_q.delete();
    repeat (2) step();
    chk("midrst_rdataen_held", 32'(rdataen), 32'd0);
    rst_n = 1'b1;
    step();
    chk("midrst_wready_rel", 32'(wready), 32'd1);
    repeat (30) step();
    chk("midrst_no_stale", 32'(out_cnt), 32'd11);

`ifdef PINGPANG_TX_UNDERFLOW_CNT_EN
    // One block out, then exactly 10 ready-but-idle cycles.
    do_reset();
    write_words(12, 20, 20);
    rready = 1'b1;
    repeat (20) step();
    rready = 1'b0;
    repeat (4) step();
    chk("ucnt_out", 32'(out_cnt), 32'd20);
    chk("ucnt_zero", 32'(ucnt), 32'd0);
    rready = 1'b1;
    repeat (10) step();
    rready = 1'b0;
    step();
    chk("ucnt_ten", 32'(ucnt), 32'd10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
